// File: rtl/shot_controller.sv
// rtl/shot_controller.sv - player projectile launch, flight, hit detection and scoring (optional miss counter: SHOT_MISS_COUNT_EN)
module shot_controller #(
    parameter int BULLET_START_Y = 448,
    parameter int BULLET_STEP    = 4,
    parameter int BULLET_HALF_W  = 2,
    parameter int BULLET_H       = 8,
    parameter int TARGET_HALF_W  = 10,
    parameter int TARGET_HALF_H  = 16,
    parameter int MAX_SCORE      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       fire,
    input  logic [9:0] ship_x,
    input  logic [9:0] target_x,
    input  logic [9:0] target_y,
    output logic [9:0] bullet_x,
    output logic [9:0] bullet_y,
    output logic       bullet_active,
    output logic       hit,
    output logic [3:0] score,
    output logic       game_done,
    output logic [3:0] misses
);

    typedef enum logic [1:0] {IDLE, FLY, HIT, DONE} state_t;

    localparam logic [9:0]  START_Y  = 10'(BULLET_START_Y);
    localparam logic [9:0]  STEP     = 10'(BULLET_STEP);
    localparam logic [10:0] X_REACH  = 11'(TARGET_HALF_W + BULLET_HALF_W);
    localparam logic [10:0] HALF_H   = 11'(TARGET_HALF_H);
    localparam logic [10:0] BUL_H    = 11'(BULLET_H);
    localparam logic [3:0]  SCORE_MX = 4'(MAX_SCORE);

    state_t      state;
    logic        fire_q;
    logic        fire_req;
    logic        fire_rise;
    logic [10:0] bx, tx, by, ty;
    logic [10:0] dx;
    logic [10:0] t_top;
    logic        collide;

    assign fire_rise = fire & ~fire_q;

    // Overlap test done at 11 bits so neither the sums nor the differences can wrap.
    always_comb begin
        bx      = {1'b0, bullet_x};
        tx      = {1'b0, target_x};
        by      = {1'b0, bullet_y};
        ty      = {1'b0, target_y};
        dx      = (bx >= tx) ? (bx - tx) : (tx - bx);
        t_top   = (ty >= HALF_H) ? (ty - HALF_H) : 11'd0;
        collide = (dx <= X_REACH) && (by <= ty + HALF_H) && (by + BUL_H >= t_top);
    end

`ifndef SHOT_MISS_COUNT_EN
    assign misses = 4'd0;
`endif

    // Game FSM: fire edge latching every cycle, everything else advances on tick only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bullet_x      <= 10'd0;
            bullet_y      <= START_Y;
            bullet_active <= 1'b0;
            hit           <= 1'b0;
            score         <= 4'd0;
            game_done     <= 1'b0;
            fire_req      <= 1'b0;
            fire_q        <= 1'b0;
`ifdef SHOT_MISS_COUNT_EN
            misses        <= 4'd0;
`endif
        end else begin
            fire_q <= fire;
            hit    <= 1'b0;
            if (state != IDLE) begin
                fire_req <= 1'b0;
            end else if (fire_rise) begin
                fire_req <= 1'b1;
            end
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (fire_req || fire_rise) begin
                            bullet_x      <= ship_x;
                            bullet_y      <= START_Y;
                            bullet_active <= 1'b1;
                            fire_req      <= 1'b0;
                            state         <= FLY;
                        end
                    end
                    FLY: begin
                        if (collide) begin
                            hit   <= 1'b1;
                            score <= (score == SCORE_MX) ? score : score + 4'd1;
                            state <= HIT;
                        end else if (bullet_y < STEP) begin
                            bullet_active <= 1'b0;
`ifdef SHOT_MISS_COUNT_EN
                            misses <= (misses == 4'd15) ? misses : misses + 4'd1;
                            if (misses >= 4'd14) begin
                                state     <= DONE;
                                game_done <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
`else
                            state <= IDLE;
`endif
                        end else begin
                            bullet_y <= bullet_y - STEP;
                        end
                    end
                    HIT: begin
                        bullet_active <= 1'b0;
                        if (score == SCORE_MX) begin
                            state     <= DONE;
                            game_done <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    DONE: begin
                        bullet_active <= 1'b0;
                        game_done     <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shot_controller.sv
// tb/tb_shot_controller.sv - directed self-checking bench for shot_controller
module tb_shot_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] ship_x = 10'd0;
    logic [9:0] target_x = 10'd100;
    logic [9:0] target_y = 10'd240;
    logic [9:0] bullet_x;
    logic [9:0] bullet_y;
    logic       bullet_active;
    logic       hit;
    logic [3:0] score;
    logic       game_done;
    logic [3:0] misses;

    int errors = 0;
    int checks = 0;

    shot_controller dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .fire          (fire),
        .ship_x        (ship_x),
        .target_x      (target_x),
        .target_y      (target_y),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_active (bullet_active),
        .hit           (hit),
        .score         (score),
        .game_done     (game_done),
        .misses        (misses)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One tick cycle with fire at level f; returns at the following negedge.
    task automatic step(input logic f);
        @(negedge clk);
        fire = f;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_miss;
`ifdef SHOT_MISS_COUNT_EN
        exp_miss = 4'd1;
`else
        exp_miss = 4'd0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_active", 32'(bullet_active), 0);
        chk("rst_y", 32'(bullet_y), 448);
        chk("rst_x", 32'(bullet_x), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_done", 32'(game_done), 0);
        chk("rst_misses", 32'(misses), 0);
        reset = 1'b0;

        // Launch with fire edge and tick in the same cycle
        ship_x = 10'd400;
        step(1'b1);
        chk("launch_x", 32'(bullet_x), 400);
        chk("launch_y", 32'(bullet_y), 448);
        chk("launch_active", 32'(bullet_active), 1);
        repeat (3) step(1'b1);
        chk("fly3_y", 32'(bullet_y), 436);
        ship_x = 10'd300;
        step(1'b1);
        chk("no_follow_x", 32'(bullet_x), 400);
        chk("no_follow_y", 32'(bullet_y), 432);
        step(1'b0);
        step(1'b1);
        chk("repress_x", 32'(bullet_x), 400);
        chk("repress_y", 32'(bullet_y), 424);

        // Asynchronous reset mid-flight takes effect before any clock edge
        @(negedge clk);
        reset = 1'b1;
        fire = 1'b0;
        #1;
        chk("async_active", 32'(bullet_active), 0);
        chk("async_y", 32'(bullet_y), 448);
        chk("async_score", 32'(score), 0);
        @(negedge clk);
        reset = 1'b0;

        // Fire edge between ticks is held and launches on the next tick
        ship_x = 10'd400;
        target_x = 10'd100;
        @(negedge clk);
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_no_tick", 32'(bullet_active), 0);
        step(1'b0);
        chk("held_launch_active", 32'(bullet_active), 1);
        chk("held_launch_x", 32'(bullet_x), 400);

        // Miss: 112 steps to reach row 0, then one more tick ends the flight
        repeat (112) step(1'b0);
        chk("miss_y0", 32'(bullet_y), 0);
        chk("miss_y0_active", 32'(bullet_active), 1);
        step(1'b0);
        chk("miss_active", 32'(bullet_active), 0);
        chk("miss_score", 32'(score), 0);
        chk("miss_count", 32'(misses), 32'(exp_miss));
        step(1'b0);
        chk("idle_stays", 32'(bullet_active), 0);

        // Ten hits against a target centred on the launch column
        target_x = 10'd400;
        target_y = 10'd240;
        for (int h = 1; h <= 10; h++) begin
            step(1'b1);
            repeat (48) step(1'b0);
            if (h == 1) begin
                chk("pre_hit_y", 32'(bullet_y), 256);
                chk("pre_hit_pulse", 32'(hit), 0);
            end
            step(1'b0);
            chk("hit_pulse", 32'(hit), 1);
            chk("hit_score", 32'(score), 32'(h));
            if (h == 1) begin
                chk("hit_y", 32'(bullet_y), 256);
                chk("hit_frame_active", 32'(bullet_active), 1);
                @(negedge clk);
                chk("hit_one_cycle", 32'(hit), 0);
            end
            step(1'b0);
            chk("post_hit_active", 32'(bullet_active), 0);
            chk("post_hit_done", 32'(game_done), (h == 10) ? 1 : 0);
        end

        // DONE ignores further presses
        step(1'b1);
        step(1'b0);
        step(1'b1);
        chk("done_active", 32'(bullet_active), 0);
        chk("done_score", 32'(score), 10);
        chk("done_flag", 32'(game_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
